com_bus_arbiter: RTL and testbench

//  Arbitrates the shared common bus (Address_Com/Data_Bus_Com/BusRd/BusRdX/Invalidate)
//  of the 4-core MESI system between 8 proc-side requesters (DL+IL per core) and
//  8 snoop-side requesters. It also arbitrates the lower-level memory's snoop write-back

---
 rtl/com_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_com_bus_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: round-robin proc tenures with snoop/memory sub-grants inside a tenure.
// Optional tenure watchdog enabled by defining COM_BUS_TIMEOUT_EN.
module com_bus_arbiter #(
    parameter int NUM_REQ        = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_proc,
    input  logic [NUM_REQ-1:0] Com_Bus_Req_snoop,
    input  logic               Mem_snoop_req,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_REQ-1:0] Com_Bus_Gnt_snoop,
    output logic               Mem_snoop_gnt,
    output logic               Bus_busy,
    output logic [2:0]         Owner_id,
    output logic               Bus_timeout
);
    // state     | meaning
    // IDLE      | no tenure, arbitrating proc requests
    // PROC_OWN  | proc owner holds the bus, snoop/mem may be granted
    // SNOOP_OWN | snoop sub-tenure inside the proc tenure
    // MEM_OWN   | memory write-back sub-tenure inside the proc tenure
    // RELEASE   | single dead cycle; its arbitration result appears after it
    typedef enum logic [2:0] {IDLE, PROC_OWN, SNOOP_OWN, MEM_OWN, RELEASE} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_proc_nxt, gnt_snoop_nxt;
    logic               mem_gnt_nxt, busy_nxt, timeout_nxt;
    logic [2:0]         owner_nxt, rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0] proc_avail, snoop_cand;
    logic               arb_found, snoop_found, owner_req, tmo_hit, in_tenure;
    logic [2:0]         arb_idx, snoop_idx;

    assign in_tenure = (state == PROC_OWN) || (state == SNOOP_OWN) || (state == MEM_OWN);
    assign owner_req = Com_Bus_Req_proc[Owner_id];

`ifdef COM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]      tenure_cnt;
    logic [NUM_REQ-1:0] tmo_mask;

    assign tmo_hit    = in_tenure && (tenure_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign proc_avail = Com_Bus_Req_proc & ~tmo_mask;

    // Timed-out owner stays masked until it lets go of its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            tenure_cnt <= '0;
            tmo_mask   <= '0;
        end else begin
            if (!in_tenure)
                tenure_cnt <= '0;
            else if (!tmo_hit)
                tenure_cnt <= tenure_cnt + CW'(1);
            tmo_mask <= tmo_mask & Com_Bus_Req_proc;
            if (tmo_hit)
                tmo_mask[Owner_id] <= 1'b1;
        end
    end
`else
    assign tmo_hit    = 1'b0;
    assign proc_avail = Com_Bus_Req_proc;
`endif

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found && proc_avail[(int'(rr_ptr) + k) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_idx   = 3'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // The owner's own snoop line never competes inside its tenure.
    assign snoop_cand  = Com_Bus_Req_snoop & ~(NUM_REQ'(1) << Owner_id);
    assign snoop_found = |snoop_cand;
    always_comb begin
        snoop_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (snoop_cand[k]) snoop_idx = 3'(k);
    end

    always_comb begin
        state_nxt     = state;
        gnt_proc_nxt  = Com_Bus_Gnt_proc;
        gnt_snoop_nxt = Com_Bus_Gnt_snoop;
        mem_gnt_nxt   = Mem_snoop_gnt;
        owner_nxt     = Owner_id;
        rr_ptr_nxt    = rr_ptr;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                gnt_proc_nxt  = '0;
                gnt_snoop_nxt = '0;
                mem_gnt_nxt   = 1'b0;
                state_nxt     = IDLE;
                if (arb_found) begin
                    gnt_proc_nxt = NUM_REQ'(1) << arb_idx;
                    owner_nxt    = arb_idx;
                    rr_ptr_nxt   = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
                    state_nxt    = PROC_OWN;
                end
            end
            PROC_OWN: begin
                if (!owner_req) begin
                    gnt_proc_nxt = '0;
                    state_nxt    = RELEASE;
                end else if (snoop_found) begin
                    gnt_snoop_nxt = NUM_REQ'(1) << snoop_idx;
                    state_nxt     = SNOOP_OWN;
                end else if (Mem_snoop_req) begin
                    mem_gnt_nxt = 1'b1;
                    state_nxt   = MEM_OWN;
                end
            end
            SNOOP_OWN: begin
                if ((Com_Bus_Req_snoop & Com_Bus_Gnt_snoop) == '0) begin
                    gnt_snoop_nxt = '0;
                    state_nxt     = PROC_OWN;
                end
            end
            MEM_OWN: begin
                if (!Mem_snoop_req) begin
                    mem_gnt_nxt = 1'b0;
                    state_nxt   = PROC_OWN;
                end
            end
            default: begin
                gnt_proc_nxt  = '0;
                gnt_snoop_nxt = '0;
                mem_gnt_nxt   = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
        if (tmo_hit) begin
            gnt_proc_nxt  = '0;
            gnt_snoop_nxt = '0;
            mem_gnt_nxt   = 1'b0;
            timeout_nxt   = 1'b1;
            state_nxt     = RELEASE;
        end
        busy_nxt = (state_nxt == PROC_OWN) || (state_nxt == SNOOP_OWN) || (state_nxt == MEM_OWN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            Com_Bus_Gnt_proc  <= '0;
            Com_Bus_Gnt_snoop <= '0;
            Mem_snoop_gnt     <= 1'b0;
            Bus_busy          <= 1'b0;
            Owner_id          <= '0;
            Bus_timeout       <= 1'b0;
            rr_ptr            <= '0;
        end else begin
            state             <= state_nxt;
            Com_Bus_Gnt_proc  <= gnt_proc_nxt;
            Com_Bus_Gnt_snoop <= gnt_snoop_nxt;
            Mem_snoop_gnt     <= mem_gnt_nxt;
            Bus_busy          <= busy_nxt;
            Owner_id          <= owner_nxt;
            Bus_timeout       <= timeout_nxt;
            rr_ptr            <= rr_ptr_nxt;
        end
    end
endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed bench for com_bus_arbiter; define COM_BUS_TIMEOUT_EN to also exercise the watchdog.
module tb_com_bus_arbiter;
`ifdef COM_BUS_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_proc, req_snoop, gnt_proc, gnt_snoop;
    logic       mem_req, mem_gnt, busy, tmo;
    logic [2:0] owner;
    int         n_checks = 0;
    int         n_errors = 0;

    com_bus_arbiter #(.NUM_REQ(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .Com_Bus_Req_proc  (req_proc),
        .Com_Bus_Req_snoop (req_snoop),
        .Mem_snoop_req     (mem_req),
        .Com_Bus_Gnt_proc  (gnt_proc),
        .Com_Bus_Gnt_snoop (gnt_snoop),
        .Mem_snoop_gnt     (mem_gnt),
        .Bus_busy          (busy),
        .Owner_id          (owner),
        .Bus_timeout       (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] rr_exp [4];
    logic       tmo_seen;

    initial begin
        rr_exp = '{8'h01, 8'h04, 8'h80, 8'h01};
        rst = 1'b1; req_proc = 8'hFF; req_snoop = 8'hFF; mem_req = 1'b1;

        // Reset with everything requesting
        tick(); tick();
        check("rst_gnt_proc", gnt_proc, 8'h00);
        check("rst_gnt_snoop", gnt_snoop, 8'h00);
        check("rst_mem_gnt", mem_gnt, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 3'd0);
        check("rst_timeout", tmo, 1'b0);
        rst = 1'b0;
        tick();
        check("first_gnt", gnt_proc, 8'h01);
        check("first_busy", busy, 1'b1);
        check("first_snoop_idle", gnt_snoop, 8'h00);
        req_proc = 8'h00; req_snoop = 8'h00; mem_req = 1'b0;
        tick();
        check("release_gnt", gnt_proc, 8'h00);
        check("release_busy", busy, 1'b0);
        tick();

        // Round robin over 0x85 with one dead cycle between tenures
        do_reset();
        req_proc = 8'h85;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_gnt", gnt_proc, rr_exp[i]);
            tick(); tick();
            check("rr_hold", gnt_proc, rr_exp[i]);
            check("rr_busy", busy, 1'b1);
            req_proc = 8'h85 & ~rr_exp[i];
            tick();
            check("rr_dead_gnt", gnt_proc, 8'h00);
            check("rr_dead_busy", busy, 1'b0);
            req_proc = (i == 3) ? 8'h00 : 8'h85;
        end
        tick();

        // Snoop grants inside owner 2 tenure
        do_reset();
        req_proc = 8'h04;
        tick();
        check("own2_gnt", gnt_proc, 8'h04);
        check("own2_id", owner, 3'd2);
        req_snoop = 8'h30;
        tick();
        check("snp_first", gnt_snoop, 8'h10);
        check("snp_proc_held", gnt_proc, 8'h04);
        req_snoop = 8'h20;
        tick();
        check("snp_drop", gnt_snoop, 8'h00);
        tick();
        check("snp_second", gnt_snoop, 8'h20);
        check("snp2_proc_held", gnt_proc, 8'h04);
        req_snoop = 8'h00;
        tick();
        req_snoop = 8'h04;
        tick();
        check("snp_owner_excl", gnt_snoop, 8'h00);
        req_snoop = 8'h00;

        // Snoop beats mem on the same cycle; mem follows
        req_snoop = 8'h02; mem_req = 1'b1;
        tick();
        check("sm_snoop", gnt_snoop, 8'h02);
        check("sm_mem_wait", mem_gnt, 1'b0);
        req_snoop = 8'h00;
        tick();
        check("sm_snoop_off", gnt_snoop, 8'h00);
        check("sm_mem_gap", mem_gnt, 1'b0);
        tick();
        check("sm_mem_gnt", mem_gnt, 1'b1);
        check("sm_proc_held", gnt_proc, 8'h04);
        req_proc = 8'h00;
        tick();
        check("perr_proc_held", gnt_proc, 8'h04);
        check("perr_mem_held", mem_gnt, 1'b1);
        mem_req = 1'b0;
        tick();
        check("perr_mem_off", mem_gnt, 1'b0);
        check("perr_proc_still", gnt_proc, 8'h04);
        tick();
        check("perr_release", gnt_proc, 8'h00);
        tick();

        // Reset inside SNOOP_OWN, then arbitration restarts at index 0
        req_proc = 8'h20;
        tick();
        check("own5_gnt", gnt_proc, 8'h20);
        req_snoop = 8'h01;
        tick();
        check("own5_snoop", gnt_snoop, 8'h01);
        rst = 1'b1;
        tick();
        check("mrst_proc", gnt_proc, 8'h00);
        check("mrst_snoop", gnt_snoop, 8'h00);
        check("mrst_busy", busy, 1'b0);
        check("mrst_owner", owner, 3'd0);
        rst = 1'b0; req_snoop = 8'h00; req_proc = 8'h41;
        tick();
        check("mrst_rr0", gnt_proc, 8'h01);
        req_proc = 8'h00;
        tick(); tick();

`ifdef COM_BUS_TIMEOUT_EN
        // Watchdog: owner 5 never lets go
        do_reset();
        req_proc = 8'hA0;
        tick();
        check("wd_gnt5", gnt_proc, 8'h20);
        for (int i = 0; i < 15; i++) tick();
        check("wd_hold16", gnt_proc, 8'h20);
        check("wd_no_pulse_yet", tmo, 1'b0);
        tick();
        check("wd_drop", gnt_proc, 8'h00);
        check("wd_pulse", tmo, 1'b1);
        check("wd_busy", busy, 1'b0);
        tick();
        check("wd_next7", gnt_proc, 8'h80);
        check("wd_pulse_end", tmo, 1'b0);
        req_proc = 8'h20;
        tick();
        check("wd_rel7", gnt_proc, 8'h00);
        tick();
        check("wd_masked", gnt_proc, 8'h00);
        tick();
        check("wd_still_masked", gnt_proc, 8'h00);
        req_proc = 8'h00;
        tick();
        req_proc = 8'h20;
        tick();
        check("wd_unmasked", gnt_proc, 8'h20);
        req_proc = 8'h00;
        tick(); tick();
`else
        // No watchdog: a long tenure is never cut
        do_reset();
        req_proc = 8'h08;
        tmo_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            tmo_seen = tmo_seen | tmo;
        end
        check("nowd_held", gnt_proc, 8'h08);
        check("nowd_no_pulse", tmo_seen, 1'b0);
        req_proc = 8'h00;
        tick(); tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
